// File: rtl/alu_shift_log_pkg.sv
// Shared definitions for the shift/logic unit: operation codes, FSM states, op classification.
// Ports: none (package). ctl codes 000-011 are shift/rotate ops, 100-111 are logic ops.
// The is_shift helper classifies an op code so the top and the step unit agree on decoding.
package alu_shift_log_pkg;

    localparam logic [2:0] CTL_ASL  = 3'b000;
    localparam logic [2:0] CTL_LSR  = 3'b001;
    localparam logic [2:0] CTL_ROL  = 3'b010;
    localparam logic [2:0] CTL_ROR  = 3'b011;
    localparam logic [2:0] CTL_AND  = 3'b100;
    localparam logic [2:0] CTL_OR   = 3'b101;
    localparam logic [2:0] CTL_XOR  = 3'b110;
    localparam logic [2:0] CTL_ANDN = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Shift/rotate ops all have the top ctl bit clear.
    function automatic logic is_shift(input logic [2:0] ctl);
        return ~ctl[2];
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One bit-position step of a shift or rotate-through-carry on (acc, c); purely combinational.
// Ports: ctl (op code), acc/c (current value) -> acc_nxt/c_nxt (value after one step).
// Logic op codes pass acc and c through unchanged; they never reach the iterative path.
module alu_shift_step
    import alu_shift_log_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       ctl,
    input  logic [WIDTH-1:0] acc,
    input  logic             c,
    output logic [WIDTH-1:0] acc_nxt,
    output logic             c_nxt
);

    always_comb begin
        acc_nxt = acc;
        c_nxt   = c;
        case (ctl)
            CTL_ASL: begin
                acc_nxt = {acc[WIDTH-2:0], 1'b0};
                c_nxt   = acc[WIDTH-1];
            end
            CTL_LSR: begin
                acc_nxt = {1'b0, acc[WIDTH-1:1]};
                c_nxt   = acc[0];
            end
            // Rotates treat {c, acc} as one (WIDTH+1)-bit ring.
            CTL_ROL: begin
                acc_nxt = {acc[WIDTH-2:0], c};
                c_nxt   = acc[WIDTH-1];
            end
            CTL_ROR: begin
                acc_nxt = {c, acc[WIDTH-1:1]};
                c_nxt   = acc[0];
            end
            default: begin
                acc_nxt = acc;
                c_nxt   = c;
            end
        endcase
    end

endmodule

// File: rtl/alu_shift_log.sv
// Handshaked logic/shift unit: single-cycle AND/OR/XOR/ANDN, iterative shift/rotate one bit per clock.
// Ports: clk/reset, in_valid/in_ready + a/b/cin/ctl/shamt request, out_valid/out_ready + y/cout/zero/neg result.
// Latency 1 for logic ops and zero-count shifts, N+1 for an N-bit shift; result held until out_ready.
module alu_shift_log
    import alu_shift_log_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    input  logic [2:0]         ctl,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y,
    output logic               cout,
    output logic               zero,
    output logic               neg
);

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               c_q, c_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;

    logic [WIDTH-1:0]   step_acc;
    logic               step_c;
    logic [WIDTH-1:0]   imm_y;
    logic               accept;

    alu_shift_step #(.WIDTH(WIDTH)) u_step (
        .ctl     (op_q),
        .acc     (acc_q),
        .c       (c_q),
        .acc_nxt (step_acc),
        .c_nxt   (step_c)
    );

    assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready);
    assign out_valid = (state_q == ST_HOLD);
    assign accept    = in_valid & in_ready;

    // Result for ops that complete on the accept edge; a zero-count shift returns a unchanged.
    always_comb begin
        imm_y = a;
        case (ctl)
            CTL_AND:  imm_y = a & b;
            CTL_OR:   imm_y = a | b;
            CTL_XOR:  imm_y = a ^ b;
            CTL_ANDN: imm_y = ~a & b;
            default:  imm_y = a;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        c_d     = c_q;
        op_d    = op_q;
        y_d     = y_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        case (state_q)
            ST_RUN: begin
                acc_d = step_acc;
                c_d   = step_c;
                cnt_d = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    y_d     = step_acc;
                    cout_d  = step_c;
                    zero_d  = (step_acc == '0);
                    neg_d   = step_acc[WIDTH-1];
                    state_d = ST_HOLD;
                end
            end
            default: begin
                // IDLE and HOLD share the accept path; in HOLD accept implies out_ready.
                if (accept) begin
                    if (is_shift(ctl) && (shamt != '0)) begin
                        acc_d   = a;
                        c_d     = cin;
                        cnt_d   = shamt;
                        op_d    = ctl;
                        state_d = ST_RUN;
                    end else begin
                        y_d     = imm_y;
                        cout_d  = cin;
                        zero_d  = (imm_y == '0);
                        neg_d   = imm_y[WIDTH-1];
                        state_d = ST_HOLD;
                    end
                end else if (state_q == ST_HOLD && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            op_q    <= 3'b000;
            y_q     <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            op_q    <= op_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign y    = y_q;
    assign cout = cout_q;
    assign zero = zero_q;
    assign neg  = neg_q;

endmodule

// File: tb/tb_alu_shift_log.sv
// Self-checking bench for alu_shift_log (WIDTH=8, SHAMT_W=4): directed cases plus random ops.
// Ports: none; drives the DUT on the falling edge and samples 1 ns after the rising edge.
// Expected results come from a word-level reference model of shifts and (WIDTH+1)-bit rotates.
module tb_alu_shift_log;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a, b;
    logic       cin;
    logic [2:0] ctl;
    logic [3:0] shamt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       cout, zero, neg;

    int n_tests = 0;
    int n_fail  = 0;

    alu_shift_log #(.WIDTH(8), .SHAMT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .ctl       (ctl),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .cout      (cout),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: shifts as plain integer shifts, rotates as rotations of the 9-bit word {cin, a}.
    function automatic void ref_op(input logic [2:0] c, input logic [7:0] av, input logic [7:0] bv,
                                   input logic ci, input int n,
                                   output logic [7:0] ry, output logic rc);
        logic [8:0]  w;
        logic [17:0] ww;
        int          k;
        ry = av;
        rc = ci;
        w  = {ci, av};
        ww = {w, w};
        k  = n % 9;
        case (c)
            3'd0: if (n > 0) begin
                ry = (n >= 8) ? 8'h00 : 8'((16'(av) << n));
                rc = (n > 8) ? 1'b0 : av[8-n];
            end
            3'd1: if (n > 0) begin
                ry = (n >= 8) ? 8'h00 : (av >> n);
                rc = (n > 8) ? 1'b0 : av[n-1];
            end
            3'd2: begin
                w  = 9'(ww >> (9 - k));
                ry = w[7:0];
                rc = w[8];
            end
            3'd3: begin
                w  = 9'(ww >> k);
                ry = w[7:0];
                rc = w[8];
            end
            3'd4: ry = av & bv;
            3'd5: ry = av | bv;
            3'd6: ry = av ^ bv;
            default: ry = ~av & bv;
        endcase
    endfunction

    // Issue one op with out_ready low, check latency and result, then drain it.
    task automatic run_op(input string tag, input logic [2:0] c, input logic [7:0] av,
                          input logic [7:0] bv, input logic ci, input logic [3:0] sh);
        logic [7:0] ey;
        logic       ec;
        int         lat;
        int         elat;
        ref_op(c, av, bv, ci, int'(sh), ey, ec);
        elat = (c[2] == 1'b0 && sh != 0) ? int'(sh) + 1 : 1;
        @(negedge clk);
        in_valid = 1'b1; ctl = c; a = av; b = bv; cin = ci; shamt = sh; out_ready = 1'b0;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        // Scramble inputs after the accept edge; the DUT must have captured them already.
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        ctl = 3'($urandom); shamt = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".y"},    32'(y),    32'(ey));
        check({tag, ".cout"}, 32'(cout), 32'(ec));
        check({tag, ".zero"}, 32'(zero), 32'(ey == 8'h00));
        check({tag, ".neg"},  32'(neg),  32'(ey[7]));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] held_y;
        int         seen;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; ctl = '0; shamt = '0;
        #1;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.y",         32'(y),         32'd0);
        check("rst.flags",     32'({cout, zero, neg}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        run_op("and",   3'd4, 8'hF0, 8'h3C, 1'b1, 4'd0);
        run_op("rol1",  3'd2, 8'h81, 8'h00, 1'b0, 4'd1);
        run_op("rol9",  3'd2, 8'h81, 8'h00, 1'b0, 4'd9);
        run_op("lsr8",  3'd1, 8'h80, 8'h00, 1'b0, 4'd8);
        run_op("asl15", 3'd0, 8'hFF, 8'h00, 1'b1, 4'd15);
        run_op("ror0",  3'd3, 8'h55, 8'h00, 1'b1, 4'd0);
        run_op("andn",  3'd7, 8'h0F, 8'hFF, 1'b0, 4'd0);
        run_op("asl8",  3'd0, 8'h01, 8'h00, 1'b0, 4'd8);
        run_op("asl9",  3'd0, 8'hFF, 8'h00, 1'b1, 4'd9);

        // Backpressure: result held while out_ready is low, pending request not accepted.
        @(negedge clk);
        in_valid = 1'b1; ctl = 3'd4; a = 8'hF0; b = 8'h3C; cin = 1'b1; shamt = 4'd0;
        @(posedge clk); #1;
        ctl = 3'd6; a = 8'hAA; b = 8'hFF; cin = 1'b0;
        held_y = y;
        check("bp.first_y", 32'(y), 32'h30);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp.stable_y",   32'(y),         32'h30);
            check("bp.stable_vld", 32'(out_valid), 32'd1);
            check("bp.in_ready",   32'(in_ready),  32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp.both_hs", 32'({in_ready, out_valid}), 32'b11);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp.next_vld", 32'(out_valid), 32'd1);
        check("bp.next_y",   32'(y),         32'h55);
        check("bp.next_neg", 32'(neg),       32'd0);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;

        // Reset during a run: outputs clear at once and the aborted op never appears.
        @(negedge clk);
        in_valid = 1'b1; ctl = 3'd3; a = 8'hC3; b = 8'h00; cin = 1'b1; shamt = 4'd7; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rmid.out_valid", 32'(out_valid), 32'd0);
        check("rmid.y",         32'(y),         32'd0);
        check("rmid.flags",     32'({cout, zero, neg}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rmid.in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rmid.no_stale", 32'(seen), 32'd0);
        out_ready = 1'b0;

        // Random ops
        for (int i = 0; i < 150; i++) begin
            run_op("rnd", 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                   4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
